dm_load_unit: RTL and testbench

Read-side companion to the data memory: accepts load requests (lw/lb/lbu/lh/lhu) from the MEM stage and drives the word index to the data memory's combinational read port. It extracts and sign/zero-extends the addressed byte or halfword, flags misaligned or out-of-range loads, and buffers results in a 2-entry response queue with valid/ready handshakes toward write-back. It sits between the MEM-stage load decode and the WB register-file write path.

---
 rtl/dm_load_unit.sv | 117 +++++++++++
 tb/tb_dm_load_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_load_unit.sv
// dm_load_unit: load-side data memory access. Extracts and extends the
// addressed byte/halfword/word, flags address errors, and buffers results
// in a 2-entry response queue toward write-back.
module dm_load_unit #(
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_addr,
    input  logic [2:0]                  req_op,
    input  logic [31:0]                 req_pc,
    output logic [$clog2(DM_WORDS)-1:0] dm_a,
    input  logic [31:0]                 dm_rdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [31:0]                 resp_data,
    output logic [31:0]                 resp_pc,
    output logic                        resp_adel,
    output logic [CNT_W-1:0]            load_cnt
);

    localparam int unsigned AW         = $clog2(DM_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4
    } load_op_e;

    logic [31:0] q_data [2];
    logic [31:0] q_pc   [2];
    logic        q_adel [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic [31:0] shifted;
    logic [31:0] ld_data;
    logic        misalign;
    logic        adel;
    logic [31:0] entry_data;

    assign dm_a       = req_addr[AW+1:2];
    assign req_ready  = (count != 2'd2);
    assign resp_valid = (count != 2'd0);
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;

    assign resp_data  = q_data[rd_ptr];
    assign resp_pc    = q_pc[rd_ptr];
    assign resp_adel  = q_adel[rd_ptr];

    // Select and extend the addressed part of the read word; detect address errors.
    always_comb begin
        shifted  = dm_rdata >> {req_addr[1:0], 3'b000};
        ld_data  = dm_rdata;
        misalign = 1'b0;
        case (req_op)
            OP_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU: ld_data = {24'd0, shifted[7:0]};
            OP_LH: begin
                ld_data  = {{16{shifted[15]}}, shifted[15:0]};
                misalign = req_addr[0];
            end
            OP_LHU: begin
                ld_data  = {16'd0, shifted[15:0]};
                misalign = req_addr[0];
            end
            default: begin
                ld_data  = dm_rdata;
                misalign = |req_addr[1:0];
            end
        endcase
        adel       = misalign || (req_addr >= ADDR_LIMIT);
        entry_data = adel ? '0 : ld_data;
    end

    // Response queue storage, pointers, occupancy and accepted-load counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
                q_adel[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            load_cnt <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= entry_data;
                q_pc[wr_ptr]   <= req_pc;
                q_adel[wr_ptr] <= adel;
                wr_ptr         <= ~wr_ptr;
                load_cnt       <= load_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_load_unit.sv
// Self-checking bench for dm_load_unit: table of single loads plus
// hand-written sequences for backpressure, streaming and reset.
module tb_dm_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic [31:0] req_pc;
    logic [31:0] dm_rdata;
    logic        resp_ready;

    logic        req_ready,  req_ready4;
    logic [9:0]  dm_a,       dm_a4;
    logic        resp_valid, resp_valid4;
    logic [31:0] resp_data,  resp_data4;
    logic [31:0] resp_pc,    resp_pc4;
    logic        resp_adel,  resp_adel4;
    logic [15:0] load_cnt;
    logic [3:0]  load_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_load_unit #(.DM_WORDS(1024), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op), .req_pc(req_pc), .dm_a(dm_a),
        .dm_rdata(dm_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_pc(resp_pc), .resp_adel(resp_adel),
        .load_cnt(load_cnt)
    );

    dm_load_unit #(.DM_WORDS(1024), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
        .req_addr(req_addr), .req_op(req_op), .req_pc(req_pc), .dm_a(dm_a4),
        .dm_rdata(dm_rdata), .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_data(resp_data4), .resp_pc(resp_pc4), .resp_adel(resp_adel4),
        .load_cnt(load_cnt4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [9:0]  exp_a;
        logic [31:0] exp_data;
        logic        exp_adel;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_op     = '0;
        req_pc     = '0;
        dm_rdata   = '0;
        resp_ready = 1'b0;

        //          op    addr          rdata         dm_a    data          adel
        vecs[0]  = '{3'd1, 32'h0000_0003, 32'h80FF_1234, 10'h000, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{3'd4, 32'h0000_0002, 32'h8001_7FFF, 10'h000, 32'h0000_8001, 1'b0};
        vecs[2]  = '{3'd3, 32'h0000_0002, 32'h8001_7FFF, 10'h000, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{3'd0, 32'h0000_0006, 32'h1234_5678, 10'h001, 32'h0000_0000, 1'b1};
        vecs[4]  = '{3'd3, 32'h0000_0001, 32'h1234_5678, 10'h000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{3'd0, 32'h0000_1000, 32'h1234_5678, 10'h000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{3'd2, 32'h0000_0002, 32'h80FF_1234, 10'h000, 32'h0000_00FF, 1'b0};
        vecs[7]  = '{3'd1, 32'h0000_0002, 32'h80FF_1234, 10'h000, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{3'd1, 32'h0000_0000, 32'h80FF_1234, 10'h000, 32'h0000_0034, 1'b0};
        vecs[9]  = '{3'd3, 32'h0000_0000, 32'h8001_7FFF, 10'h000, 32'h0000_7FFF, 1'b0};
        vecs[10] = '{3'd4, 32'h0000_0010, 32'h1234_8000, 10'h004, 32'h0000_8000, 1'b0};
        vecs[11] = '{3'd0, 32'h0000_0FFC, 32'hDEAD_BEEF, 10'h3FF, 32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{3'd5, 32'h0000_0008, 32'hCAFE_F00D, 10'h002, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{3'd2, 32'h0000_2003, 32'h80FF_1234, 10'h000, 32'h0000_0000, 1'b1};
        vecs[14] = '{3'd7, 32'h0000_0005, 32'h1234_5678, 10'h001, 32'h0000_0000, 1'b1};
        vecs[15] = '{3'd1, 32'h0000_0FFF, 32'h7F00_0000, 10'h3FF, 32'h0000_007F, 1'b0};

        // Reset state
        tick();
        reset = 1'b0;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_pc", resp_pc, 32'd0);
        check("reset resp_adel", 32'(resp_adel), 32'd0);
        check("reset load_cnt", 32'(load_cnt), 32'd0);

        // Table of single loads, each one accepted and then drained
        exp_cnt    = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_op    = vecs[i].op;
            req_addr  = vecs[i].addr;
            dm_rdata  = vecs[i].rdata;
            req_pc    = 32'h400 + 32'(i) * 4;
            #1;
            check($sformatf("vec%0d dm_a", i), 32'(dm_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'd1);
            tick();
            req_valid = 1'b0;
            exp_cnt   = exp_cnt + 1;
            check($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("vec%0d resp_data", i), resp_data, vecs[i].exp_data);
            check($sformatf("vec%0d resp_adel", i), 32'(resp_adel), 32'(vecs[i].exp_adel));
            check($sformatf("vec%0d resp_pc", i), resp_pc, 32'h400 + 32'(i) * 4);
            check($sformatf("vec%0d load_cnt", i), 32'(load_cnt), exp_cnt);
            tick();
            check($sformatf("vec%0d drained", i), 32'(resp_valid), 32'd0);
        end

        // Empty queue with resp_ready high: nothing pops, nothing appears
        tick();
        check("empty stays empty", 32'(resp_valid), 32'd0);
        check("empty req_ready", 32'(req_ready), 32'd1);

        // Backpressure: fill the queue, third load waits for the first pop
        do_reset();
        req_op    = 3'd0;
        req_valid = 1'b1;
        req_addr  = 32'h10; dm_rdata = 32'h1111_1111; req_pc = 32'h100;
        tick();
        req_addr  = 32'h14; dm_rdata = 32'h2222_2222; req_pc = 32'h104;
        check("bp first head", resp_data, 32'h1111_1111);
        check("bp ready after 1", 32'(req_ready), 32'd1);
        tick();
        req_addr  = 32'h18; dm_rdata = 32'h3333_3333; req_pc = 32'h108;
        check("bp full ready", 32'(req_ready), 32'd0);
        check("bp full cnt", 32'(load_cnt), 32'd2);
        tick();
        check("bp held ready", 32'(req_ready), 32'd0);
        check("bp held cnt", 32'(load_cnt), 32'd2);
        check("bp held head", resp_data, 32'h1111_1111);
        resp_ready = 1'b1;
        tick();
        check("bp pop1 head", resp_data, 32'h2222_2222);
        check("bp pop1 ready", 32'(req_ready), 32'd1);
        check("bp pop1 cnt", 32'(load_cnt), 32'd2);
        tick();
        req_valid = 1'b0;
        check("bp third head", resp_data, 32'h3333_3333);
        check("bp third pc", resp_pc, 32'h108);
        check("bp third cnt", 32'(load_cnt), 32'd3);
        tick();
        check("bp drained", 32'(resp_valid), 32'd0);

        // Streaming: one load per cycle, no bubbles; also exercises counter wrap
        do_reset();
        resp_ready = 1'b1;
        req_op     = 3'd0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i) * 4;
            dm_rdata  = 32'hA5A5_0000 + 32'(i);
            req_pc    = 32'h2000 + 32'(i) * 4;
            tick();
            check($sformatf("stream%0d valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("stream%0d data", i), resp_data, 32'hA5A5_0000 + 32'(i));
            check($sformatf("stream%0d ready", i), 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        tick();
        check("stream drained", 32'(resp_valid), 32'd0);
        check("stream load_cnt", 32'(load_cnt), 32'd20);
        check("stream load_cnt w4", 32'(load_cnt4), 32'd4);

        // Reset with two entries queued, simultaneous request must be dropped
        do_reset();
        req_op    = 3'd0;
        req_valid = 1'b1;
        req_addr  = 32'h20; dm_rdata = 32'h5555_5555; req_pc = 32'h300;
        tick();
        tick();
        check("pre-reset full", 32'(req_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("mid reset resp_valid", 32'(resp_valid), 32'd0);
        check("mid reset req_ready", 32'(req_ready), 32'd1);
        check("mid reset load_cnt", 32'(load_cnt), 32'd0);
        check("mid reset resp_data", resp_data, 32'd0);
        check("mid reset resp_pc", resp_pc, 32'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post reset quiet%0d", i), 32'(resp_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
